// File: rtl/ram_dumper_pkg.sv
// Shared constants for the RAM dumper: address width, sync byte, FSM encodings
// and the header byte selector.
package ram_dumper_pkg;

  localparam int unsigned RAM_ADDR_BITS     = 16;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'h55;
  localparam logic [2:0]  HDR_LAST          = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD_REQ,
    RD_WAIT,
    SEND,
    WAIT_DONE,
    CSUM,
    FIN
  } state_t;

  // Which kind of byte is outstanding while in WAIT_DONE.
  typedef enum logic [1:0] {
    PH_HDR,
    PH_DATA,
    PH_CSUM
  } phase_t;

  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [7:0]  sync,
                                          input logic [15:0] addr,
                                          input logic [15:0] len);
    logic [7:0] b;
    case (idx)
      3'd0:    b = sync;
      3'd1:    b = addr[15:8];
      3'd2:    b = addr[7:0];
      3'd3:    b = len[15:8];
      default: b = len[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ram_dumper_rise_detect.sv
// Rising-edge detector for the trigger level; history clears on reset so a
// trigger already high at reset release counts as an edge.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/ram_dumper.sv
// Streams a RAM window over a UART as: sync, addr hi/lo, len hi/lo, data bytes,
// 8-bit data checksum. One byte in flight at a time, paced by tx_done.
module ram_dumper
  import ram_dumper_pkg::*;
#(
  parameter int unsigned ADDR_BITS = RAM_ADDR_BITS,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trigger,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [15:0]          length,
  output logic [ADDR_BITS-1:0] ram_addr,
  input  logic [7:0]           ram_data,
  output logic [7:0]           tx_data,
  output logic                 tx_wr,
  input  logic                 tx_done,
  output logic                 dumping,
  output logic                 done
);

  state_t      state_q, state_d;
  phase_t      phase_q;
  logic [2:0]  hdr_idx_q;
  logic [15:0] count_q;
  logic [7:0]  csum_q;
  logic [15:0] addr16;
  logic        rise;

  rise_detect u_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (trigger),
    .rise (rise)
  );

  generate
    if (ADDR_BITS >= 16) begin : g_addr_trunc
      assign addr16 = ram_addr[15:0];
    end else begin : g_addr_ext
      assign addr16 = {{(16-ADDR_BITS){1'b0}}, ram_addr};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:            if (rise) state_d = HDR;
      HDR, SEND, CSUM: state_d = WAIT_DONE;
      RD_REQ:          state_d = RD_WAIT;
      RD_WAIT:         state_d = SEND;
      WAIT_DONE: begin
        if (tx_done) begin
          if (phase_q == PH_CSUM)                              state_d = FIN;
          else if (phase_q == PH_HDR && hdr_idx_q != HDR_LAST) state_d = HDR;
          else if (count_q == '0)                              state_d = CSUM;
          else                                                 state_d = RD_REQ;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_wr   = (state_q == HDR) || (state_q == SEND) || (state_q == CSUM);
    dumping = (state_q != IDLE);
    done    = (state_q == FIN);
  end

  // tx_data is loaded on the edge entering each send state so it is already
  // stable during the single tx_wr cycle; ram_addr holds the header address
  // until the first data byte is sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      tx_data   <= '0;
      count_q   <= '0;
      csum_q    <= '0;
      hdr_idx_q <= '0;
      phase_q   <= PH_HDR;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            ram_addr  <= start_addr;
            count_q   <= length;
            csum_q    <= '0;
            hdr_idx_q <= '0;
            phase_q   <= PH_HDR;
            tx_data   <= SYNC_BYTE;
          end
        end
        RD_WAIT: begin
          tx_data <= ram_data;
          csum_q  <= csum_q + ram_data;
        end
        SEND: begin
          ram_addr <= ram_addr + 1'b1;
          count_q  <= count_q - 1'b1;
          phase_q  <= PH_DATA;
        end
        WAIT_DONE: begin
          if (state_d == HDR) begin
            hdr_idx_q <= hdr_idx_q + 3'd1;
            tx_data   <= hdr_byte(hdr_idx_q + 3'd1, SYNC_BYTE, addr16, count_q);
          end else if (state_d == CSUM) begin
            tx_data <= csum_q;
            phase_q <= PH_CSUM;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
